// File: rtl/operand_fetch.sv
// operand_fetch
//   Operand-fetch stage between decode and execute. It accepts decoded
//   instructions on a valid/ready handshake, drives the register-file read
//   addresses, and collects the operands one cycle later because the file
//   read is registered. Read-after-write hazards against the writeback port
//   are resolved before the operands reach execute. Two slots give full
//   throughput: slot A waits on register-file data and slot B is the output
//   register.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     decode handshake (in_ready is combinational)
//   in_rs0/in_rs1         source indices
//   in_rd/in_ctrl         destination index and control, passed through
//   rf_r0_addr/rf_r1_addr register-file read addresses (combinational)
//   rf_r0/rf_r1           register-file read data, one cycle after address
//   wb_en/wb_addr/wb_data writeback port, same strobe as the file write
//   out_valid/out_ready   execute handshake (out_valid is registered)
//   out_op0/out_op1       resolved operands
//   out_rd/out_ctrl       destination index and control
module operand_fetch #(
  parameter int ADDR_W = 5,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rs0,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic [31:0]       rf_r0_addr,
  output logic [31:0]       rf_r1_addr,
  input  logic [31:0]       rf_r0,
  input  logic [31:0]       rf_r1,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [31:0]       wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_op0,
  output logic [31:0]       out_op1,
  output logic [ADDR_W-1:0] out_rd,
  output logic [CTRL_W-1:0] out_ctrl
);

  logic              a_v;
  logic              b_v;
  logic [ADDR_W-1:0] a_rs0;
  logic [ADDR_W-1:0] a_rs1;
  logic [ADDR_W-1:0] a_rd;
  logic [CTRL_W-1:0] a_ctrl;
  logic [ADDR_W-1:0] b_rs0;
  logic [ADDR_W-1:0] b_rs1;
  logic              a_fwd0;
  logic              a_fwd1;
  logic [31:0]       a_fwd_data0;
  logic [31:0]       a_fwd_data1;

  logic              a_adv;
  logic              accept;
  logic [ADDR_W-1:0] rd_idx0;
  logic [ADDR_W-1:0] rd_idx1;
  logic [31:0]       a_op0;
  logic [31:0]       a_op1;

  assign a_adv    = a_v && (!b_v || out_ready);
  assign in_ready = !a_v || a_adv;
  assign accept   = in_valid && in_ready;

  // A stalled slot A keeps re-reading its own sources, so the registered
  // read data always matches whatever slot A holds when it finally advances.
  assign rd_idx0    = (a_v && !a_adv) ? a_rs0 : in_rs0;
  assign rd_idx1    = (a_v && !a_adv) ? a_rs1 : in_rs1;
  assign rf_r0_addr = {{(32-ADDR_W){1'b0}}, rd_idx0};
  assign rf_r1_addr = {{(32-ADDR_W){1'b0}}, rd_idx1};

  // Operand resolution for slot A: a write landing this cycle is newest;
  // a write captured during the read cycle was missed by the file (it
  // returns pre-write data); otherwise the file data is current.
  always_comb begin
    a_op0 = rf_r0;
    a_op1 = rf_r1;
    if (wb_en && (wb_addr == a_rs0)) a_op0 = wb_data;
    else if (a_fwd0)                 a_op0 = a_fwd_data0;
    if (wb_en && (wb_addr == a_rs1)) a_op1 = wb_data;
    else if (a_fwd1)                 a_op1 = a_fwd_data1;
  end

  assign out_valid = b_v;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_v         <= 1'b0;
      b_v         <= 1'b0;
      a_rs0       <= '0;
      a_rs1       <= '0;
      a_rd        <= '0;
      a_ctrl      <= '0;
      b_rs0       <= '0;
      b_rs1       <= '0;
      a_fwd0      <= 1'b0;
      a_fwd1      <= 1'b0;
      a_fwd_data0 <= '0;
      a_fwd_data1 <= '0;
      out_op0     <= '0;
      out_op1     <= '0;
      out_rd      <= '0;
      out_ctrl    <= '0;
    end else begin
      a_fwd0      <= wb_en && (wb_addr == rd_idx0);
      a_fwd1      <= wb_en && (wb_addr == rd_idx1);
      a_fwd_data0 <= wb_data;
      a_fwd_data1 <= wb_data;

      if (accept) begin
        a_v    <= 1'b1;
        a_rs0  <= in_rs0;
        a_rs1  <= in_rs1;
        a_rd   <= in_rd;
        a_ctrl <= in_ctrl;
      end else if (a_adv) begin
        a_v <= 1'b0;
      end

      if (a_adv) begin
        b_v      <= 1'b1;
        b_rs0    <= a_rs0;
        b_rs1    <= a_rs1;
        out_op0  <= a_op0;
        out_op1  <= a_op1;
        out_rd   <= a_rd;
        out_ctrl <= a_ctrl;
      end else if (b_v && out_ready) begin
        b_v <= 1'b0;
      end else if (b_v) begin
        // Held output snoops writeback so execute never sees stale data.
        if (wb_en && (wb_addr == b_rs0)) out_op0 <= wb_data;
        if (wb_en && (wb_addr == b_rs1)) out_op1 <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs0;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rd;
  logic [15:0] in_ctrl;
  logic [31:0] rf_r0_addr;
  logic [31:0] rf_r1_addr;
  logic [31:0] rf_r0;
  logic [31:0] rf_r1;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_op0;
  logic [31:0] out_op1;
  logic [4:0]  out_rd;
  logic [15:0] out_ctrl;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:31];

  operand_fetch #(.ADDR_W(5), .CTRL_W(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs0(in_rs0), .in_rs1(in_rs1), .in_rd(in_rd), .in_ctrl(in_ctrl),
    .rf_r0_addr(rf_r0_addr), .rf_r1_addr(rf_r1_addr),
    .rf_r0(rf_r0), .rf_r1(rf_r1),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op0(out_op0), .out_op1(out_op1),
    .out_rd(out_rd), .out_ctrl(out_ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model: registered read returning pre-write data.
  always @(posedge clk) begin
    if (wb_en) mem[wb_addr] <= wb_data;
    rf_r0 <= mem[rf_r0_addr[4:0]];
    rf_r1 <= mem[rf_r1_addr[4:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic issue(input logic [4:0] r0, input logic [4:0] r1,
                       input logic [4:0] rd, input logic [15:0] c);
    in_valid = 1'b1; in_rs0 = r0; in_rs1 = r1; in_rd = rd; in_ctrl = c;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", out_valid); end
    total++; if (out_op0 !== 32'h0) begin bad++; $display("FAIL reset_op0 got=%0h exp=0", out_op0); end
    total++; if (out_op1 !== 32'h0) begin bad++; $display("FAIL reset_op1 got=%0h exp=0", out_op1); end
    total++; if (out_rd !== 5'h0) begin bad++; $display("FAIL reset_rd got=%0h exp=0", out_rd); end
    total++; if (out_ctrl !== 16'h0) begin bad++; $display("FAIL reset_ctrl got=%0h exp=0", out_ctrl); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
    reset = 1'b0;
  endtask

  task automatic preload();
    wr(5'd1, 32'h101);
    wr(5'd2, 32'h202);
    wr(5'd3, 32'h11);
    wr(5'd4, 32'h22);
    wr(5'd5, 32'h505);
    wr(5'd6, 32'h606);
  endtask

  task automatic test_basic();
    issue(5'd3, 5'd4, 5'd7, 16'h1234);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready got=%0h exp=1", in_ready); end
    total++; if (rf_r0_addr !== 32'd3) begin bad++; $display("FAIL basic_addr0 got=%0h exp=3", rf_r0_addr); end
    total++; if (rf_r1_addr !== 32'd4) begin bad++; $display("FAIL basic_addr1 got=%0h exp=4", rf_r1_addr); end
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%0h exp=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0h exp=1", out_valid); end
    total++; if (out_op0 !== 32'h11) begin bad++; $display("FAIL basic_op0 got=%0h exp=11", out_op0); end
    total++; if (out_op1 !== 32'h22) begin bad++; $display("FAIL basic_op1 got=%0h exp=22", out_op1); end
    total++; if (out_rd !== 5'd7) begin bad++; $display("FAIL basic_rd got=%0h exp=7", out_rd); end
    total++; if (out_ctrl !== 16'h1234) begin bad++; $display("FAIL basic_ctrl got=%0h exp=1234", out_ctrl); end
  endtask

  task automatic test_wb_accept();
    issue(5'd3, 5'd3, 5'd9, 16'h00a5);
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hAA;
    tick();
    in_valid = 1'b0; wb_en = 1'b0;
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL wbacc_valid got=%0h exp=1", out_valid); end
    total++; if (out_op0 !== 32'hAA) begin bad++; $display("FAIL wbacc_op0 got=%0h exp=aa", out_op0); end
    total++; if (out_op1 !== 32'hAA) begin bad++; $display("FAIL wbacc_op1 got=%0h exp=aa", out_op1); end
  endtask

  task automatic test_wb_slot_a();
    issue(5'd3, 5'd4, 5'd10, 16'h0bb0);
    tick();
    in_valid = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'hBB;
    tick();
    wb_en = 1'b0;
    total++; if (out_op0 !== 32'hAA) begin bad++; $display("FAIL wba_op0 got=%0h exp=aa", out_op0); end
    total++; if (out_op1 !== 32'hBB) begin bad++; $display("FAIL wba_op1 got=%0h exp=bb", out_op1); end
    total++; if (out_rd !== 5'd10) begin bad++; $display("FAIL wba_rd got=%0h exp=a", out_rd); end
  endtask

  task automatic test_stall_snoop();
    issue(5'd3, 5'd4, 5'd11, 16'h5a5a);
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;                                     // stall 1
    total++; if (out_op1 !== 32'hBB) begin bad++; $display("FAIL stall_op1_first got=%0h exp=bb", out_op1); end
    tick();                                               // stall 2
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid got=%0h exp=1", out_valid); end
    tick();                                               // stall 3
    wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h55;
    tick();                                               // stall 4
    wb_en = 1'b0;
    total++; if (out_op1 !== 32'h55) begin bad++; $display("FAIL snoop_op1 got=%0h exp=55", out_op1); end
    total++; if (out_op0 !== 32'hAA) begin bad++; $display("FAIL snoop_op0 got=%0h exp=aa", out_op0); end
    tick();                                               // stall 5
    total++; if (out_op1 !== 32'h55) begin bad++; $display("FAIL snoop_hold got=%0h exp=55", out_op1); end
    total++; if (out_ctrl !== 16'h5a5a) begin bad++; $display("FAIL snoop_ctrl got=%0h exp=5a5a", out_ctrl); end
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_drain got=%0h exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    issue(5'd1, 5'd2, 5'd1, 16'h0001);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready1 got=%0h exp=1", in_ready); end
    tick();
    issue(5'd3, 5'd4, 5'd2, 16'h0002);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready2 got=%0h exp=1", in_ready); end
    tick();
    issue(5'd5, 5'd6, 5'd3, 16'h0003);
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_full_ready got=%0h exp=0", in_ready); end
    total++; if (rf_r0_addr !== 32'd3) begin bad++; $display("FAIL b2b_addr0 got=%0h exp=3", rf_r0_addr); end
    total++; if (rf_r1_addr !== 32'd4) begin bad++; $display("FAIL b2b_addr1 got=%0h exp=4", rf_r1_addr); end
    total++; if (out_op0 !== 32'h101 || out_op1 !== 32'h202 || out_rd !== 5'd1)
      begin bad++; $display("FAIL b2b_first got=%0h/%0h/%0h exp=101/202/1", out_op0, out_op1, out_rd); end
    tick();
    total++; if (in_ready !== 1'b0 || rf_r0_addr !== 32'd3)
      begin bad++; $display("FAIL b2b_hold got=%0h/%0h exp=0/3", in_ready, rf_r0_addr); end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_release_ready got=%0h exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_op0 !== 32'hAA || out_op1 !== 32'h55 || out_rd !== 5'd2)
      begin bad++; $display("FAIL b2b_second got=%0h/%0h/%0h/%0h exp=1/aa/55/2", out_valid, out_op0, out_op1, out_rd); end
    tick();
    total++; if (out_valid !== 1'b1 || out_op0 !== 32'h505 || out_op1 !== 32'h606 || out_rd !== 5'd3)
      begin bad++; $display("FAIL b2b_third got=%0h/%0h/%0h/%0h exp=1/505/606/3", out_valid, out_op0, out_op1, out_rd); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%0h exp=0", out_valid); end
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0;
    issue(5'd1, 5'd2, 5'd4, 16'h0004);
    tick();
    issue(5'd5, 5'd6, 5'd5, 16'h0005);
    tick();
    in_valid = 1'b0;
    #1;
    total++; if (in_ready !== 1'b0 || out_valid !== 1'b1)
      begin bad++; $display("FAIL rstfull_pre got=%0h/%0h exp=0/1", in_ready, out_valid); end
    reset = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0 || out_op0 !== 32'h0 || out_op1 !== 32'h0 || out_rd !== 5'h0 || out_ctrl !== 16'h0)
      begin bad++; $display("FAIL rstfull_out got=%0h/%0h/%0h/%0h/%0h exp=0", out_valid, out_op0, out_op1, out_rd, out_ctrl); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstfull_ready got=%0h exp=1", in_ready); end
    reset = 1'b0;
    out_ready = 1'b1;
    issue(5'd5, 5'd6, 5'd6, 16'h0006);
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstfull_stale got=%0h exp=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1 || out_op0 !== 32'h505 || out_op1 !== 32'h606 || out_rd !== 5'd6)
      begin bad++; $display("FAIL rstfull_next got=%0h/%0h/%0h/%0h exp=1/505/606/6", out_valid, out_op0, out_op1, out_rd); end
    tick();
  endtask

  task automatic test_index_zero_priority();
    wr(5'd0, 32'h77);
    issue(5'd0, 5'd0, 5'd12, 16'h000c);
    tick();
    in_valid = 1'b0;
    tick();
    total++; if (out_op0 !== 32'h77 || out_op1 !== 32'h77)
      begin bad++; $display("FAIL zero_ops got=%0h/%0h exp=77/77", out_op0, out_op1); end
    // Captured forward from the read cycle must lose to a newer write.
    issue(5'd2, 5'd1, 5'd13, 16'h000d);
    wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'hC1;
    tick();
    in_valid = 1'b0;
    wb_data = 32'hC2;
    tick();
    wb_en = 1'b0;
    total++; if (out_op0 !== 32'hC2) begin bad++; $display("FAIL prio_op0 got=%0h exp=c2", out_op0); end
    total++; if (out_op1 !== 32'h101) begin bad++; $display("FAIL prio_op1 got=%0h exp=101", out_op1); end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_rs0 = '0; in_rs1 = '0; in_rd = '0; in_ctrl = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
    test_reset();
    preload();
    test_basic();
    test_wb_accept();
    test_wb_slot_a();
    test_stall_snoop();
    test_back_to_back();
    test_reset_full();
    test_index_zero_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch stage between instruction decode and execute. It accepts decoded instructions over a valid/ready handshake and drives the register-file read addresses. It collects the two source operands one cycle later, because the register file read is registered and returns pre-write data. It resolves read-after-write hazards against the writeback port and presents coherent operands to execute through a two-entry pipeline. Throughput is one instruction per cycle.

## Interface

Parameters:
- ADDR_W, 5, register index width (register file of 2**ADDR_W words)
- CTRL_W, 16, width of opaque control bundle passed through to execute

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_rs0, in_rs1  in  ADDR_W  source register indices
- in_rd  in  ADDR_W  destination index, passed through
- in_ctrl  in  CTRL_W  control bundle, passed through
- rf_r0_addr, rf_r1_addr  out  32  register-file read addresses, zero-extended
- rf_r0, rf_r1  in  32  register-file read data, valid the cycle after the address
- wb_en  in  1  writeback strobe, the same signal that drives the register-file write enable
- wb_addr  in  ADDR_W  writeback index
- wb_data  in  32  writeback data
- out_valid  out  1  operands valid to execute
- out_ready  in  1  execute accepts
- out_op0, out_op1  out  32  resolved operands
- out_rd  out  ADDR_W  destination index
- out_ctrl  out  CTRL_W  control bundle

## Operation

- The stage has two slots. Slot A is the fetch slot, waiting on register-file data. Slot B is the output register. Each slot has a valid flag: a_v and b_v.
- a_adv = a_v && (!b_v || out_ready).
- in_ready = !a_v || a_adv. This signal is combinational.
- Accept = in_valid && in_ready. On accept, slot A loads in_rs0, in_rs1, in_rd and in_ctrl, and a_v is set.
- Read-address mux: rf_rX_addr = (a_v && !a_adv) ? a_rsX : in_rsX.
  - A stalled slot A therefore re-reads its sources every cycle.
- Forward capture, every cycle, per source X:
  - a_fwdX <= wb_en && (wb_addr == rf_rX_addr[ADDR_W-1:0]).
  - a_fwd_dataX <= wb_data.
  - These cover the write the register file misses in the same cycle it is read.
- Slot A operand, per source X, in priority order:
  - if wb_en && wb_addr == a_rsX, use wb_data;
  - else if a_fwdX, use a_fwd_dataX;
  - else use rf_rX.
- On a_adv:
  - slot B loads the slot A operands, a_rs0, a_rs1, rd and ctrl, and b_v is set;
  - a_v clears, unless an accept occurs in the same cycle.
- Slot B snoop: while b_v && !out_ready, for each X, if wb_en && wb_addr == b_rsX, then out_opX <= wb_data.
- When b_v && out_ready && !a_adv, b_v clears.
- Equal indices on both sources forward independently to both operands.
- No register index is special; index 0 is an ordinary register.

## Timing

- Reset values:
  - a_v = b_v = 0, so out_valid = 0;
  - out_op0, out_op1, out_rd and out_ctrl = 0;
  - a_fwd0 and a_fwd1 = 0;
  - in_ready = 1 during and after reset.
- Reset mid-operation discards both slots at the next edge. No partial instruction is emitted.
- Latency: an instruction accepted at edge t sits in slot A during cycle t+1. out_valid is high from edge t+2.
- Throughput: with out_ready held high, one instruction per cycle and no bubbles.
- Full condition: a_v && b_v && !out_ready. In this state in_ready = 0 and the read addresses hold slot A's sources.
- Release from full:
  - the out_ready=1 cycle transfers B and advances A into B;
  - in_ready = 1 in that cycle, so a new accept refills A.
- out_valid, out_op* and out_ctrl come directly from registers. in_ready and rf_r*_addr are combinational.
- Input-side handshake is AXI-style. Decode holds its fields stable while in_valid && !in_ready. The stage must not depend on in_valid being withdrawn.

## Test plan

1. Register file preloaded with r3=0x11 and r4=0x22. Accept rs0=3, rs1=4 at edge t with no writeback. Required: out_op0=0x11, out_op1=0x22, out_valid high at t+2.
2. wb_en with wb_addr=3 and wb_data=0xAA in the accept cycle, rs0=rs1=3. Required: out_op0=out_op1=0xAA, although the register file returned the old value 0x11.
3. wb_en with wb_addr=4 and wb_data=0xBB in the slot A cycle (t+1). Required: out_op1=0xBB.
4. Hold out_ready=0 for 5 cycles after out_valid. Write r4=0x55 on the third stall cycle. Required: out_op1 changes to 0x55 on the next edge and then holds; out_op0 is unchanged.
5. Issue three back-to-back instructions with out_ready=0. Required: in_ready drops after the second accept, and rf_r*_addr equals the second instruction's sources. Then raise out_ready. Required: all three emerge in order on consecutive cycles, with operands correct against a reference model.
6. Assert reset for one cycle while both slots are full. Required: out_valid=0 and outputs zero at the next edge, in_ready=1, and the next accepted instruction emerges with correct operands at reset release plus 2 cycles.
